// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage to data-memory request/status handshake bundle
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [1:0]  status;

  modport master (
    output req, we, addr, w_data,
    input  r_data, status
  );

  modport slave (
    input  req, we, addr, w_data,
    output r_data, status
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM answering the MEM stage after a fixed latency
// Optional DMEM_STATS_EN adds completed-access and busy-cycle counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned LATENCY     = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     o_access_cnt,
  output logic [31:0]     o_busy_cnt
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BUSY  = 2'b01,
    S_DONE  = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [31:0]     w_off;
  logic            w_addr_ok;
  logic            w_accept;
  logic            w_enter_done;
  logic            w_we;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;

  assign w_off     = bus.addr - BASE_ADDR;
  assign w_addr_ok = (bus.addr[1:0] == 2'b00) && (bus.addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_accept  = (r_state == S_IDLE) && bus.req;

  // A zero-latency access completes on its accept edge, so it must use the live inputs
  assign w_we    = w_accept ? bus.we           : r_we;
  assign w_idx   = w_accept ? w_off[AW+1:2]    : r_idx;
  assign w_wdata = w_accept ? bus.w_data       : r_wdata;

  assign w_enter_done = (w_next == S_DONE);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (!w_addr_ok) begin
            w_next = S_ERROR;
          end else if (LATENCY == 0) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = LAT_M1;
          end
        end
      end
      S_BUSY: begin
        if (!bus.req) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= bus.we;
        r_idx   <= w_off[AW+1:2];
        r_wdata <= bus.w_data;
      end
      if (w_enter_done && !w_we) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // RAM keeps its contents across reset
  always_ff @(posedge i_clk) begin
    if (w_enter_done && w_we) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign bus.status = r_state;
  assign bus.r_data = r_rdata;

`ifdef DMEM_STATS_EN
  logic [31:0] r_access_cnt;
  logic [31:0] r_busy_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_access_cnt <= 32'd0;
      r_busy_cnt   <= 32'd0;
    end else begin
      if (w_enter_done) begin
        r_access_cnt <= r_access_cnt + 32'd1;
      end
      if (r_state == S_BUSY) begin
        r_busy_cnt <= r_busy_cnt + 32'd1;
      end
    end
  end

  assign o_access_cnt = r_access_cnt;
  assign o_busy_cnt   = r_busy_cnt;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY=3 and LATENCY=0 instances)
module tb_dmem_responder;

  localparam int          LAT    = 3;
  localparam int          DEPTH  = 1024;
  localparam int          DEPTH0 = 16;
  localparam logic [31:0] BASE   = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

`ifdef DMEM_STATS_EN
  logic [31:0] acc_cnt, busy_cnt, acc_cnt0, busy_cnt0;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus)
`ifdef DMEM_STATS_EN
    ,
    .o_access_cnt (acc_cnt),
    .o_busy_cnt   (busy_cnt)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus0)
`ifdef DMEM_STATS_EN
    ,
    .o_access_cnt (acc_cnt0),
    .o_busy_cnt   (busy_cnt0)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model  [logic [31:0]];
  logic [31:0] model0 [logic [31:0]];
  logic [31:0] exp_q  [$];
  logic [31:0] last_rd  = 32'd0;
  logic [31:0] last_rd0 = 32'd0;

  // Drives one request and returns what the DUT showed; comparisons live in the scenario tasks.
  task automatic run_access(input bit sel0, input bit we, input logic [31:0] a, input logic [31:0] d,
                            output int busy, output logic [1:0] fin, output logic [31:0] rd);
    logic [1:0] st;
    @(negedge clk);
    if (sel0) begin
      bus0.req = 1'b1; bus0.we = we; bus0.addr = a; bus0.w_data = d;
    end else begin
      bus.req = 1'b1; bus.we = we; bus.addr = a; bus.w_data = d;
    end
    busy = 0;
    fin  = 2'bxx;
    rd   = 32'hxxxx_xxxx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      st = sel0 ? bus0.status : bus.status;
      if (st == 2'b01) begin
        busy++;
        bus.we = 1'($urandom); bus.addr = $urandom; bus.w_data = $urandom;
      end else begin
        fin = st;
        rd  = sel0 ? bus0.r_data : bus.r_data;
        break;
      end
    end
    bus.req  = 1'b0; bus.addr  = $urandom; bus.w_data  = $urandom; bus.we  = 1'($urandom);
    bus0.req = 1'b0; bus0.addr = $urandom; bus0.w_data = $urandom; bus0.we = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL reset_status: got %b expected 00", bus.status); end
    n_cmp++; if (bus.r_data !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", bus.r_data); end
    n_cmp++; if (bus0.status !== 2'b00) begin n_bad++; $display("FAIL reset_status0: got %b expected 00", bus0.status); end
    n_cmp++; if (bus0.r_data !== 32'd0) begin n_bad++; $display("FAIL reset_rdata0: got %h expected 0", bus0.r_data); end
`ifdef DMEM_STATS_EN
    n_cmp++; if (acc_cnt !== 32'd0 || busy_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", acc_cnt, busy_cnt); end
`endif
    rst = 1'b0;
    last_rd = 32'd0; last_rd0 = 32'd0;
  endtask

  task automatic test_store_load();
    int busy; logic [1:0] fin; logic [31:0] rd, e, d, a;
    logic [31:0] addrs [4];
    addrs[0] = BASE; addrs[1] = BASE + 32'(4 * (DEPTH - 1)); addrs[2] = BASE + 32'h100; addrs[3] = BASE + 32'h7FC;
    model[BASE + 32'h10] = 32'hDEAD_BEEF;
    run_access(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, busy, fin, rd);
    n_cmp++; if (busy !== LAT) begin n_bad++; $display("FAIL store_busy_cycles: got %0d expected %0d", busy, LAT); end
    n_cmp++; if (fin !== 2'b10) begin n_bad++; $display("FAIL store_done: got %b expected 10", fin); end
    @(negedge clk);
    n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL store_after_done: got %b expected 00", bus.status); end
    exp_q.push_back(model[BASE + 32'h10]);
    run_access(0, 1'b0, BASE + 32'h10, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd = e;
    n_cmp++; if (busy !== LAT) begin n_bad++; $display("FAIL load_busy_cycles: got %0d expected %0d", busy, LAT); end
    n_cmp++; if (fin !== 2'b10) begin n_bad++; $display("FAIL load_done: got %b expected 10", fin); end
    n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL load_rdata: got %h expected %h", rd, e); end
    foreach (addrs[i]) begin
      a = addrs[i]; d = $urandom;
      model[a] = d;
      run_access(0, 1'b1, a, d, busy, fin, rd);
      n_cmp++; if (fin !== 2'b10 || rd !== last_rd) begin n_bad++; $display("FAIL store_hold %h: got %b/%h expected 10/%h", a, fin, rd, last_rd); end
    end
    foreach (addrs[i]) begin
      a = addrs[i];
      exp_q.push_back(model[a]);
      run_access(0, 1'b0, a, 32'h0, busy, fin, rd);
      e = exp_q.pop_front(); last_rd = e;
      n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL load_back %h: got %b/%h expected 10/%h", a, fin, rd, e); end
    end
  endtask

  task automatic test_error();
    int busy; logic [1:0] fin; logic [31:0] rd, e;
    logic [31:0] bad [4];
    bad[0] = BASE + 32'h2; bad[1] = 32'h0FFF_FFFC; bad[2] = BASE + 32'(4 * DEPTH); bad[3] = BASE + 32'h1;
    foreach (bad[i]) begin
      run_access(0, 1'b1, bad[i], 32'hBAD0_0000 | 32'(i), busy, fin, rd);
      n_cmp++; if (busy !== 0 || fin !== 2'b11) begin n_bad++; $display("FAIL err_status %h: got busy=%0d %b expected busy=0 11", bad[i], busy, fin); end
      n_cmp++; if (rd !== last_rd) begin n_bad++; $display("FAIL err_rdata_hold %h: got %h expected %h", bad[i], rd, last_rd); end
      @(negedge clk);
      n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL err_then_idle %h: got %b expected 00", bad[i], bus.status); end
    end
    exp_q.push_back(model[BASE]);
    run_access(0, 1'b0, BASE, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd = e;
    n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL err_ram_word0: got %b/%h expected 10/%h", fin, rd, e); end
    exp_q.push_back(model[BASE + 32'(4 * (DEPTH - 1))]);
    run_access(0, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd = e;
    n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL err_ram_last: got %b/%h expected 10/%h", fin, rd, e); end
  endtask

  task automatic test_abort();
    int busy; logic [1:0] fin; logic [31:0] rd, e;
    model[BASE + 32'h20] = 32'h1111_2222;
    run_access(0, 1'b1, BASE + 32'h20, 32'h1111_2222, busy, fin, rd);
    n_cmp++; if (fin !== 2'b10) begin n_bad++; $display("FAIL abort_prestore: got %b expected 10", fin); end
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE + 32'h20; bus.w_data = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.status !== 2'b01) begin n_bad++; $display("FAIL abort_busy%0d: got %b expected 01", i, bus.status); end
    end
    bus.req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL abort_idle%0d: got %b expected 00", i, bus.status); end
    end
    exp_q.push_back(model[BASE + 32'h20]);
    run_access(0, 1'b0, BASE + 32'h20, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd = e;
    n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL abort_no_write: got %b/%h expected 10/%h", fin, rd, e); end
  endtask

  task automatic test_reset_mid_busy();
    int busy; logic [1:0] fin; logic [31:0] rd, e;
    model[BASE + 32'h30] = 32'h3333_4444;
    run_access(0, 1'b1, BASE + 32'h30, 32'h3333_4444, busy, fin, rd);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE + 32'h30; bus.w_data = 32'h7777_8888;
    @(negedge clk);
    n_cmp++; if (bus.status !== 2'b01) begin n_bad++; $display("FAIL rstbusy_busy: got %b expected 01", bus.status); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL rstbusy_status: got %b expected 00", bus.status); end
    n_cmp++; if (bus.r_data !== 32'd0) begin n_bad++; $display("FAIL rstbusy_rdata: got %h expected 0", bus.r_data); end
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'd0; last_rd0 = 32'd0;
    exp_q.push_back(model[BASE + 32'h30]);
    run_access(0, 1'b0, BASE + 32'h30, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd = e;
    n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL rstbusy_dropped: got %b/%h expected 10/%h", fin, rd, e); end
  endtask

  task automatic test_back_to_back();
    int cyc, d1, d2, ndone; logic [31:0] e;
    d1 = -1; d2 = -1; ndone = 0; cyc = 0;
    exp_q.push_back(model[BASE + 32'h10]);
    exp_q.push_back(model[BASE + 32'h10]);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = BASE + 32'h10;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      cyc++;
      if (d1 >= 0 && cyc == d1 + 1) begin
        n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL b2b_gap: got %b expected 00", bus.status); end
      end
      if (bus.status == 2'b10) begin
        e = exp_q.pop_front(); last_rd = e;
        n_cmp++; if (bus.r_data !== e) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h expected %h", ndone, bus.r_data, e); end
        if (ndone == 0) d1 = cyc; else d2 = cyc;
        ndone++;
      end
    end
    bus.req = 1'b0;
    n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    n_cmp++; if (d2 - d1 !== LAT + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected %0d", d2 - d1, LAT + 2); end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    n_cmp++; if (bus.status !== 2'b00) begin n_bad++; $display("FAIL b2b_release: got %b expected 00", bus.status); end
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    int busy; logic [1:0] fin; logic [31:0] rd, a0, b0;
    @(negedge clk);
    a0 = acc_cnt; b0 = busy_cnt;
    run_access(0, 1'b0, BASE + 32'h10, 32'h0, busy, fin, rd);
    run_access(0, 1'b0, BASE, 32'h0, busy, fin, rd);
    model[BASE + 32'h40] = 32'h4040_4040;
    run_access(0, 1'b1, BASE + 32'h40, 32'h4040_4040, busy, fin, rd);
    last_rd = model[BASE];
    @(negedge clk);
    n_cmp++; if (acc_cnt - a0 !== 32'd3) begin n_bad++; $display("FAIL stats_access: got %0d expected 3", acc_cnt - a0); end
    n_cmp++; if (busy_cnt - b0 !== 32'd9) begin n_bad++; $display("FAIL stats_busy: got %0d expected 9", busy_cnt - b0); end
  endtask
`endif

  task automatic test_latency0();
    int busy; logic [1:0] fin; logic [31:0] rd, e;
    logic [31:0] last;
    last = BASE + 32'(4 * (DEPTH0 - 1));
    model0[BASE] = 32'hCAFE_0001;
    run_access(1, 1'b1, BASE, 32'hCAFE_0001, busy, fin, rd);
    n_cmp++; if (busy !== 0 || fin !== 2'b10) begin n_bad++; $display("FAIL lat0_store: got busy=%0d %b expected busy=0 10", busy, fin); end
    @(negedge clk);
    n_cmp++; if (bus0.status !== 2'b00) begin n_bad++; $display("FAIL lat0_idle: got %b expected 00", bus0.status); end
    model0[last] = 32'h0F0F_1234;
    run_access(1, 1'b1, last, 32'h0F0F_1234, busy, fin, rd);
    run_access(1, 1'b1, BASE + 32'(4 * DEPTH0), 32'hBAD0_BAD0, busy, fin, rd);
    n_cmp++; if (fin !== 2'b11 || rd !== last_rd0) begin n_bad++; $display("FAIL lat0_err: got %b/%h expected 11/%h", fin, rd, last_rd0); end
    exp_q.push_back(model0[BASE]);
    run_access(1, 1'b0, BASE, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd0 = e;
    n_cmp++; if (busy !== 0 || fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL lat0_load0: got %0d/%b/%h expected 0/10/%h", busy, fin, rd, e); end
    exp_q.push_back(model0[last]);
    run_access(1, 1'b0, last, 32'h0, busy, fin, rd);
    e = exp_q.pop_front(); last_rd0 = e;
    n_cmp++; if (fin !== 2'b10 || rd !== e) begin n_bad++; $display("FAIL lat0_load_last: got %b/%h expected 10/%h", fin, rd, e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.w_data = 32'h0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.w_data = 32'h0;
    test_reset();
    test_store_load();
    test_error();
    test_abort();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
